uc_control: RTL and testbench
=============================

Name: uc_control

Overview:
- Control unit for the single-cycle microcontroller datapath.
- Decodes the 6-bit Opcode and the registered zero flag z, and drives s_inc, s_inm, we3, wez and Op into the datapath.
- Adds a run/step/halt execution FSM, a pc_en strobe for the datapath PC enable (PC register gains an enable in the same datapath revision), a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
CNT_W, 16, width of the retired-instruction counter
OP_PASS, 3'b000, ALU code that passes operand A (used by LI)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Opcode  input  6  instr[15:10] from the datapath
z  input  1  registered zero flag from the datapath
run  input  1  level; 1 = free-running execution
step  input  1  single-step request; a rising edge executes one instruction
s_inc  output  1  1 = PC+1; 0 = load instr[9:0]
s_inm  output  1  1 = immediate operand path
we3  output  1  register-file write enable
wez  output  1  zero-flag write enable
Op  output  3  ALU operation
pc_en  output  1  PC register load enable
halted  output  1  1 while in HALT
illegal  output  1  sticky; set on a reserved opcode
icount  output  CNT_W  retired-instruction counter

Behaviour:
- Reset:
  - Asynchronous and active-low: reset=0 immediately forces state=STOP, step_q=0, icount=0, illegal=0.
  - Derived outputs during reset: pc_en=0, we3=0, wez=0, halted=0.
- Opcode map (decode is combinational on Opcode):
  - 1ooo xx: ALU reg-reg. Op=Opcode[4:2], s_inm=0, s_inc=1, we3=1, wez=1.
  - 01xx xx: LI. Op=OP_PASS, s_inm=1, s_inc=1, we3=1, wez=0.
  - 000000: NOP. s_inc=1, no writes.
  - 001000: J. s_inc=0.
  - 001001: JZ. s_inc=~z.
  - 001010: JNZ. s_inc=z.
  - 001011: HALT. s_inc=1, no writes.
  - All other codes: reserved, behave as NOP; on issue, illegal is set to 1 and holds until reset.
  - Non-ALU codes: Op=OP_PASS, s_inm=0.
- Output gating:
  - Op, s_inm and s_inc always reflect the decode.
  - we3, wez and pc_en equal the decoded values ANDed with issue.
  - issue=1 only in RUN, or in STEP.
- State machine (registered, one state per clock):
  - STOP: issue=0.
    - run=1 -> RUN.
    - Otherwise, step=1 and step_q=0 -> STEP.
    - run has priority over step.
  - STEP: issue=1 for exactly one cycle, then -> STOP. run is ignored during this cycle.
  - RUN: issue=1 every cycle.
    - Opcode=HALT: the HALT instruction retires (pc_en=1, PC advances past it) -> HALT.
    - Otherwise, run=0 sampled -> STOP. The current cycle's instruction still completes; the run check applies on the edge ending that cycle.
  - HALT: issue=0, halted=1. Exit only by reset; run and step are ignored.
  - HALT in STEP: retires and -> HALT, not STOP.
- step_q: registers step every cycle for edge detection. A step held high produces exactly one STEP.
- icount:
  - Increments by 1 on every cycle with issue=1, including the HALT and reserved-opcode cycles.
  - Wraps modulo 2^CNT_W, with no saturation.
- Latency:
  - Control outputs are combinational on the current Opcode and z, within the same cycle.
  - State, icount and illegal update on the clk edge.
- Simultaneous events:
  - Reset asserted mid-instruction: the write is suppressed immediately because pc_en, we3 and wez drop asynchronously.
  - JZ in the same cycle as a wez write: uses the old registered z. This is the required semantics; there is no bypass.

Decomposition:
- Shared package uc_pkg holds:
  - Opcode constants: OPC_NOP, OPC_J, OPC_JZ, OPC_JNZ, OPC_HALT, plus LI and ALU prefix masks.
  - State encoding: STOP, RUN, STEP, HALT, 2 bits.
  - OP_PASS.
- Sub-module uc_decode:
  - Purely combinational Opcode/z -> raw control vector plus a reserved flag.
  - uc_control contains the FSM, gating, counter and flags.

Test Plan:
- Reset with run=1, then release: cycle 1 RUN with Opcode=100100 -> Op=3'b001, we3=1, wez=1, s_inc=1, pc_en=1, icount=1.
- RUN with Opcode=001001: z=1 -> s_inc=0; z=0 -> s_inc=1. Repeat with 001010 and check the inverted response.
- run=0, step held high for 5 cycles with Opcode=010011 -> exactly one cycle with we3=1, s_inm=1, Op=000, wez=0; icount increments by exactly 1; state returns to STOP.
- RUN, Opcode=001011 -> that cycle pc_en=1; next cycle halted=1, pc_en=0. Toggling run/step has no effect; reset=0 -> halted=0.
- RUN with Opcode=000111 -> no writes, pc_en=1, illegal=1 and still 1 after 10 further NOPs.
- CNT_W=4 with 17 issued cycles -> icount=1 (wrap). Assert reset mid-cycle with we3=1 -> we3 drops to 0 immediately; icount=0.

Source files
------------

// File: rtl/uc_pkg.sv
// uc_pkg: shared opcode constants, FSM state encoding and control vector type
package uc_pkg;
    localparam logic [2:0] OP_PASS  = 3'b000;
    localparam logic [5:0] OPC_NOP  = 6'b000000;
    localparam logic [5:0] OPC_J    = 6'b001000;
    localparam logic [5:0] OPC_JZ   = 6'b001001;
    localparam logic [5:0] OPC_JNZ  = 6'b001010;
    localparam logic [5:0] OPC_HALT = 6'b001011;
    localparam logic [5:0] ALU_MASK = 6'b100000;
    localparam logic [5:0] ALU_PFX  = 6'b100000;
    localparam logic [5:0] LI_MASK  = 6'b110000;
    localparam logic [5:0] LI_PFX   = 6'b010000;
    typedef enum logic [1:0] {STOP = 2'd0, RUN = 2'd1, STEP = 2'd2, HALT = 2'd3} state_t;
    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
        logic       pc_en;
    } ctrl_t;
endpackage

// File: rtl/uc_if.sv
// uc_if: control-unit <-> datapath signal bundle
interface uc_if;
    logic [5:0] Opcode;
    logic       z;
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] Op;
    logic       pc_en;
    modport master (input Opcode, z, output s_inc, s_inm, we3, wez, Op, pc_en);
    modport slave  (output Opcode, z, input s_inc, s_inm, we3, wez, Op, pc_en);
endinterface

// File: rtl/uc_decode.sv
// uc_decode: combinational opcode/z decode into a raw, ungated control vector
module uc_decode import uc_pkg::*; #(
    parameter logic [2:0] OP_PASS = uc_pkg::OP_PASS
) (
    input  logic [5:0] opcode,
    input  logic       z,
    output ctrl_t      ctrl,
    output logic       halt,
    output logic       rsvd
);
    logic alu, li;
    always_comb begin
        alu = (opcode & ALU_MASK) == ALU_PFX;
        li = (opcode & LI_MASK) == LI_PFX;
        halt = opcode == OPC_HALT;
        rsvd = !(alu || li || opcode inside {OPC_NOP, OPC_J, OPC_JZ, OPC_JNZ, OPC_HALT});
        ctrl.op = alu ? opcode[4:2] : OP_PASS;
        ctrl.s_inm = li;
        ctrl.we3 = alu || li;
        ctrl.wez = alu;
        // conditional jumps test the registered z, never a same-cycle update
        ctrl.s_inc = opcode == OPC_J ? 1'b0 : opcode == OPC_JZ ? ~z : opcode == OPC_JNZ ? z : 1'b1;
        ctrl.pc_en = 1'b1;
    end
endmodule

// File: rtl/uc_control.sv
// uc_control: run/step/halt execution FSM, output gating, retired-instruction
// counter and sticky illegal-opcode flag around the opcode decoder
module uc_control import uc_pkg::*; #(
    parameter int         CNT_W   = 16,
    parameter logic [2:0] OP_PASS = uc_pkg::OP_PASS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    uc_if.master             dp,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] icount
);
    ctrl_t  ctrl;
    logic   halt, rsvd, issue, step_q;
    state_t state, nxt;
    uc_decode #(.OP_PASS(OP_PASS)) u_dec (.opcode(dp.Opcode), .z(dp.z), .ctrl(ctrl), .halt(halt), .rsvd(rsvd));
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= STOP;
            step_q <= 1'b0;
            icount <= '0;
            illegal <= 1'b0;
        end else begin
            state <= nxt;
            step_q <= step;
            if (issue) icount <= icount + 1'b1;
            if (issue && rsvd) illegal <= 1'b1;
        end
    always_comb begin
        nxt = state;
        issue = state == RUN || state == STEP;
        unique case (state)
            STOP: nxt = run ? RUN : (step && !step_q) ? STEP : STOP;
            STEP: nxt = halt ? HALT : STOP;
            RUN:  nxt = halt ? HALT : run ? RUN : STOP;
            HALT: nxt = HALT;
        endcase
    end
    // state clears asynchronously, so gated strobes drop the moment reset asserts
    assign dp.s_inc = ctrl.s_inc;
    assign dp.s_inm = ctrl.s_inm;
    assign dp.Op = ctrl.op;
    assign dp.we3 = ctrl.we3 && issue;
    assign dp.wez = ctrl.wez && issue;
    assign dp.pc_en = ctrl.pc_en && issue;
    assign halted = state == HALT;
endmodule

// File: tb/tb_uc_control.sv
// tb_uc_control: directed stimulus with a cycle-stamped scoreboard; icount uses CNT_W=4 to reach wrap
module tb_uc_control;
  typedef struct {
    string       name;
    int          cyc;
    logic [13:0] v;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       halted, illegal;
  logic [3:0] icount;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  exp_t       q[$];
  uc_if dp ();
  uc_control #(.CNT_W(4)) dut (.clk(clk), .reset(reset), .run(run), .step(step), .dp(dp.master),
                               .halted(halted), .illegal(illegal), .icount(icount));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    logic [13:0] act;
    act = {dp.s_inc, dp.s_inm, dp.we3, dp.wez, dp.Op, dp.pc_en, halted, illegal, icount};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (e.cyc != cyc || act !== e.v) begin
        fails++;
        $display("FAIL %s: got {s_inc,s_inm,we3,wez,Op,pc_en,halted,illegal,icount}=%b required %b (cycle %0d/%0d)",
                 e.name, act, e.v, cyc, e.cyc);
      end
    end
  end
  task automatic drv(input logic [5:0] op, input logic zz, input logic rn, input logic st);
    @(posedge clk);
    #1;
    dp.Opcode = op;
    dp.z = zz;
    run = rn;
    step = st;
  endtask
  task automatic chk(input string n, input logic si, input logic sm, input logic w3, input logic wz,
                     input logic [2:0] op, input logic pe, input logic h, input logic il, input logic [3:0] ic);
    exp_t e;
    e.name = n;
    e.cyc = cyc;
    e.v = {si, sm, w3, wz, op, pe, h, il, ic};
    q.push_back(e);
  endtask
  initial begin
    dp.Opcode = 6'b100100;
    dp.z = 1'b0;
    drv(6'b100100, 1'b0, 1'b1, 1'b0);
    chk("reset", 1, 0, 0, 0, 3'b001, 0, 0, 0, 4'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    drv(6'b100100, 1'b0, 1'b1, 1'b0);
    chk("alu", 1, 0, 1, 1, 3'b001, 1, 0, 0, 4'd0);
    drv(6'b001001, 1'b1, 1'b1, 1'b0);
    chk("jz_taken", 0, 0, 0, 0, 3'b000, 1, 0, 0, 4'd1);
    drv(6'b001001, 1'b0, 1'b1, 1'b0);
    chk("jz_not", 1, 0, 0, 0, 3'b000, 1, 0, 0, 4'd2);
    drv(6'b001010, 1'b1, 1'b1, 1'b0);
    chk("jnz_z1", 1, 0, 0, 0, 3'b000, 1, 0, 0, 4'd3);
    drv(6'b001010, 1'b0, 1'b1, 1'b0);
    chk("jnz_z0", 0, 0, 0, 0, 3'b000, 1, 0, 0, 4'd4);
    drv(6'b000000, 1'b0, 1'b0, 1'b0);
    chk("nop_last", 1, 0, 0, 0, 3'b000, 1, 0, 0, 4'd5);
    drv(6'b010011, 1'b0, 1'b0, 1'b1);
    chk("stop_idle", 1, 1, 0, 0, 3'b000, 0, 0, 0, 4'd6);
    drv(6'b010011, 1'b0, 1'b0, 1'b1);
    chk("step_li", 1, 1, 1, 0, 3'b000, 1, 0, 0, 4'd6);
    drv(6'b010011, 1'b0, 1'b0, 1'b1);
    chk("step_after", 1, 1, 0, 0, 3'b000, 0, 0, 0, 4'd7);
    drv(6'b010011, 1'b0, 1'b0, 1'b1);
    chk("step_held", 1, 1, 0, 0, 3'b000, 0, 0, 0, 4'd7);
    drv(6'b010011, 1'b0, 1'b0, 1'b1);
    chk("step_held2", 1, 1, 0, 0, 3'b000, 0, 0, 0, 4'd7);
    drv(6'b001011, 1'b0, 1'b1, 1'b0);
    chk("stop_pre_halt", 1, 0, 0, 0, 3'b000, 0, 0, 0, 4'd7);
    drv(6'b001011, 1'b0, 1'b1, 1'b0);
    chk("halt_issue", 1, 0, 0, 0, 3'b000, 1, 0, 0, 4'd7);
    drv(6'b100100, 1'b0, 1'b0, 1'b1);
    chk("halted", 1, 0, 0, 0, 3'b001, 0, 1, 0, 4'd8);
    drv(6'b100100, 1'b0, 1'b1, 1'b0);
    chk("halt_hold", 1, 0, 0, 0, 3'b001, 0, 1, 0, 4'd8);
    drv(6'b100100, 1'b0, 1'b1, 1'b1);
    chk("halt_hold2", 1, 0, 0, 0, 3'b001, 0, 1, 0, 4'd8);
    drv(6'b100100, 1'b0, 1'b1, 1'b0);
    #1 reset = 1'b0;
    chk("halt_reset", 1, 0, 0, 0, 3'b001, 0, 0, 0, 4'd0);
    #1;
    tests++;
    if (halted !== 1'b0) begin
      fails++;
      $display("FAIL halt_reset_direct: halted=%b required 0", halted);
    end
    tests++;
    if (icount !== 4'd0) begin
      fails++;
      $display("FAIL halt_reset_icount: icount=%0d required 0", icount);
    end
    @(negedge clk);
    #1 reset = 1'b1;
    drv(6'b000111, 1'b0, 1'b1, 1'b0);
    chk("rsvd", 1, 0, 0, 0, 3'b000, 1, 0, 0, 4'd0);
    for (int i = 1; i <= 16; i++) begin
      drv(6'b000000, 1'b0, 1'b1, 1'b0);
      if (i == 1) chk("nop_ill", 1, 0, 0, 0, 3'b000, 1, 0, 1, 4'd1);
      if (i == 10) chk("ill_sticky", 1, 0, 0, 0, 3'b000, 1, 0, 1, 4'd10);
      if (i == 16) chk("wrap0", 1, 0, 0, 0, 3'b000, 1, 0, 1, 4'd0);
    end
    drv(6'b100100, 1'b0, 1'b1, 1'b0);
    chk("wrap", 1, 0, 1, 1, 3'b001, 1, 0, 1, 4'd1);
    drv(6'b100100, 1'b0, 1'b1, 1'b0);
    chk("pre_rst", 1, 0, 1, 1, 3'b001, 1, 0, 1, 4'd2);
    drv(6'b100100, 1'b0, 1'b1, 1'b0);
    #1 reset = 1'b0;
    chk("async_rst", 1, 0, 0, 0, 3'b001, 0, 0, 0, 4'd0);
    #1;
    tests++;
    if (dp.we3 !== 1'b0) begin
      fails++;
      $display("FAIL async_rst_we3: we3=%b required 0", dp.we3);
    end
    tests++;
    if (dp.pc_en !== 1'b0) begin
      fails++;
      $display("FAIL async_rst_pc_en: pc_en=%b required 0", dp.pc_en);
    end
    tests++;
    if (icount !== 4'd0) begin
      fails++;
      $display("FAIL async_rst_icount: icount=%0d required 0", icount);
    end
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: never compared, required %b", e.name, e.v);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
